// File: rtl/not_impl_if.sv
// Handshake bundle for the nonimplication block: operand side and result side.
interface not_impl_if #(
   parameter int unsigned WIDTH = 1
) ();
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] not_c;
   logic             any_c;
   logic [CW-1:0]    pop_c;

   // The block itself
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, not_c, any_c, pop_c
   );

   // Producer/consumer driving the block
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, not_c, any_c, pop_c
   );
endinterface

// File: rtl/not_impl.sv
// Registered bitwise nonimplication (a & ~b) with OR-reduction and popcount,
// buffered by an output register plus one skid register.
module not_impl #(
   parameter int unsigned WIDTH = 1
) (
   input logic      clk,
   input logic      rst,
   not_impl_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0] c;
      logic             any;
      logic [CW-1:0]    pop;
   } res_t;

   res_t new_res;
   res_t out_q, out_d;
   res_t skid_q, skid_d;
   logic out_valid_q, out_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic in_ready_q;
   logic in_fire, out_fire;

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   // Result of the operands presented this cycle
   always_comb begin
      new_res     = '0;
      new_res.c   = bus.a & ~bus.b;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         new_res.pop = new_res.pop + CW'(new_res.c[i]);
      end
      new_res.any = |new_res.c;
   end

   // Next-state of the two-entry buffer; the skid entry is always older than a new pair
   always_comb begin
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (out_fire || !out_valid_q) begin
         if (skid_valid_q) begin
            // in_ready is low whenever skid is occupied, so no new pair competes here
            out_valid_d  = 1'b1;
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_d       = new_res;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_d       = new_res;
      end
   end

   // State registers; reset empties both entries and holds in_ready low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         in_ready_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_q        <= out_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         in_ready_q   <= ~skid_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.not_c     = out_q.c;
   assign bus.any_c     = out_q.any;
   assign bus.pop_c     = out_q.pop;
endmodule

// File: tb/tb_not_impl.sv
// Bench for not_impl: WIDTH=1 truth table plus a WIDTH=4 instance checked
// against a transaction-level queue model.
module tb_not_impl;
   logic clk;
   logic rst;

   not_impl_if #(.WIDTH(1)) bus1 ();
   not_impl_if #(.WIDTH(4)) bus4 ();

   not_impl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   not_impl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_out = 0;
   logic [3:0]  exp_q[$];
   logic        rdy_gate;
   string       phase;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of the WIDTH=4 instance, entered and left at a falling edge.
   // The model is an in-order queue holding at most two results.
   task automatic cycle(input logic iv, input logic [3:0] ia, input logic [3:0] ib,
                        input logic ordy);
      logic       exp_rdy;
      logic       exp_vld;
      logic [3:0] f;
      bus4.in_valid  = iv;
      bus4.a         = ia;
      bus4.b         = ib;
      bus4.out_ready = ordy;
      exp_rdy = rdy_gate && (exp_q.size() < 2);
      exp_vld = exp_q.size() > 0;
      check({phase, ".in_ready"}, 64'(bus4.in_ready), 64'(exp_rdy));
      check({phase, ".out_valid"}, 64'(bus4.out_valid), 64'(exp_vld));
      if (exp_vld) begin
         f = exp_q[0];
         check({phase, ".not_c"}, 64'(bus4.not_c), 64'(f));
         check({phase, ".any_c"}, 64'(bus4.any_c), 64'(f != 4'd0));
         check({phase, ".pop_c"}, 64'(bus4.pop_c), 64'($countones(f)));
      end
      @(posedge clk);
      if (exp_vld && ordy) begin
         void'(exp_q.pop_front());
         n_out++;
      end
      if (iv && exp_rdy) exp_q.push_back(ia & ~ib);
      rdy_gate = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] tt;
      logic       tv;
      rst = 1'b1;
      rdy_gate = 1'b0;
      phase = "reset";
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.w4.out_valid", 64'(bus4.out_valid), 64'd0);
      check("reset.w4.in_ready", 64'(bus4.in_ready), 64'd0);
      check("reset.w4.not_c", 64'(bus4.not_c), 64'd0);
      check("reset.w4.any_c", 64'(bus4.any_c), 64'd0);
      check("reset.w4.pop_c", 64'(bus4.pop_c), 64'd0);
      check("reset.w1.out_valid", 64'(bus1.out_valid), 64'd0);
      check("reset.w1.in_ready", 64'(bus1.in_ready), 64'd0);
      rst = 1'b0;
      check("w1.ready_before_edge", 64'(bus1.in_ready), 64'd0);
      @(negedge clk);
      check("w1.ready_after_edge", 64'(bus1.in_ready), 64'd1);
      check("w4.ready_after_edge", 64'(bus4.in_ready), 64'd1);
      rdy_gate = 1'b1;

      // WIDTH=1 truth table, back to back, one-cycle latency
      for (int i = 0; i < 4; i++) begin
         tt = 2'(i);
         bus1.in_valid  = 1'b1;
         bus1.a         = tt[1];
         bus1.b         = tt[0];
         bus1.out_ready = 1'b1;
         tv = tt[1] & ~tt[0];
         @(negedge clk);
         check("tt.out_valid", 64'(bus1.out_valid), 64'd1);
         check("tt.not_c", 64'(bus1.not_c), 64'(tv));
         check("tt.any_c", 64'(bus1.any_c), 64'(tv));
         check("tt.pop_c", 64'(bus1.pop_c), 64'(tv));
      end
      bus1.in_valid = 1'b0;
      @(negedge clk);
      check("tt.drain", 64'(bus1.out_valid), 64'd0);

      phase = "vec4";
      cycle(1'b1, 4'b1100, 4'b1010, 1'b1);
      cycle(1'b1, 4'b1111, 4'b0000, 1'b1);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

      phase = "bp";
      cycle(1'b1, 4'b1000, 4'b0000, 1'b0);
      cycle(1'b1, 4'b0001, 4'b0000, 1'b0);
      check("bp.full_ready", 64'(bus4.in_ready), 64'd0);
      check("bp.held", 64'(bus4.not_c), 64'b1000);
      cycle(1'b1, 4'(($urandom)), 4'(($urandom)), 1'b0);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
      check("bp.second", 64'(bus4.not_c), 64'b0001);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

      phase = "stream";
      n_out = 0;
      for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom), 4'($urandom), 1'b1);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
      check("stream.count", 64'(n_out), 64'd8);

      phase = "idle";
      for (int i = 0; i < 6; i++) cycle(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));

      phase = "rand";
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 9) < 7), 4'($urandom), 4'($urandom),
               1'($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

      phase = "rstmid";
      cycle(1'b1, 4'b1010, 4'b0000, 1'b0);
      cycle(1'b1, 4'b0111, 4'b0001, 1'b0);
      check("rstmid.full", 64'(bus4.in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      check("rstmid.out_valid", 64'(bus4.out_valid), 64'd0);
      check("rstmid.in_ready", 64'(bus4.in_ready), 64'd0);
      check("rstmid.not_c", 64'(bus4.not_c), 64'd0);
      check("rstmid.any_c", 64'(bus4.any_c), 64'd0);
      check("rstmid.pop_c", 64'(bus4.pop_c), 64'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rdy_gate = 1'b0;
      phase = "postrst";
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'($urandom), 4'($urandom), 1'b1);
      cycle(1'b1, 4'b0110, 4'b0010, 1'b1);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);
      cycle(1'b0, 4'b0000, 4'b0000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/not_impl.md
NOT_IMPL -- requirements
Module: not_impl

Interface
REQ-001 Parameter WIDTH, default 1, operand and result bit width; legal range 1..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of the population-count output; SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair a/b presented this cycle.
REQ-006 in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 a  input  WIDTH  antecedent operand.
REQ-008 b  input  WIDTH  consequent operand.
REQ-009 out_valid  output  1  result outputs hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 not_c  output  WIDTH  bitwise nonimplication result, !(a => b).
REQ-012 any_c  output  1  OR-reduction of not_c.
REQ-013 pop_c  output  CW  number of 1 bits in not_c.

Function
REQ-014 Per bit i: not_c[i] SHALL equal a[i] AND NOT b[i]; equivalently 1 only for a=1, b=0.
REQ-015 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 Output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-017 Results SHALL be computed from a and b at the input-transfer edge and registered, together with any_c and pop_c.
REQ-018 Latency SHALL be exactly 1 cycle: a pair accepted at edge N SHALL be visible with out_valid=1 after edge N.
REQ-019 Storage SHALL be two entries: one output register and one skid register.
REQ-020 in_ready SHALL be a registered signal that equals NOT (skid register occupied).
REQ-021 When the output register is empty or is being transferred out, an accepted pair SHALL load the output register directly.
REQ-022 When the output register is full and stalled (out_ready=0), an accepted pair SHALL load the skid register.
REQ-023 When the output transfers and the skid register is occupied, the skid contents SHALL move to the output register at the same edge, and the skid register SHALL become empty.
REQ-024 Results SHALL leave the block in acceptance order; a pair SHALL never be dropped or duplicated.
REQ-025 If input and output transfer happen at the same edge with the skid register empty, the output register SHALL take the new result and out_valid SHALL stay 1.
REQ-026 While out_valid=1 and out_ready=0, not_c, any_c and pop_c SHALL be held stable.
REQ-027 any_c SHALL be 1 iff pop_c is nonzero.
REQ-028 pop_c SHALL range over 0..WIDTH, with no overflow at pop_c=WIDTH.
REQ-029 a and b SHALL be ignored when in_valid=0 or in_ready=0.
REQ-030 With out_ready held 1, the block SHALL sustain 1 transfer per cycle.

Reset
REQ-031 Asserting rst SHALL immediately clear both entries, with no clock required.
REQ-032 During reset: out_valid=0, in_ready=0, not_c=0, any_c=0, pop_c=0.
REQ-033 in_ready SHALL rise to 1 on the first rising edge after rst deasserts.
REQ-034 Reset mid-operation SHALL discard all buffered results; no pre-reset result SHALL appear after reset.

Verification
REQ-035 Bench SHALL apply the WIDTH=1 truth table with out_ready=1: (a,b)=(0,0)->0; (0,1)->0; (1,0)->1; (1,1)->0. Each result SHALL arrive 1 cycle after acceptance, with any_c=not_c and pop_c=not_c.
REQ-036 Bench SHALL check WIDTH=4, a=1100, b=1010 -> not_c=0100, any_c=1, pop_c=1; and a=1111, b=0000 -> not_c=1111, pop_c=4.
REQ-037 Bench SHALL check backpressure with WIDTH=4: hold out_ready=0 and send 2 pairs, (1000,0000) then (0001,0000). in_ready SHALL go 0 after the second pair. The held output SHALL stay 1000. Raising out_ready SHALL then deliver 1000 followed by 0001.
REQ-038 Bench SHALL check streaming: 8 back-to-back pairs with out_ready=1 SHALL give 8 consecutive out_valid cycles with the results in order.
REQ-039 Bench SHALL check reset mid-operation: assert rst asynchronously while both entries are full. All outputs SHALL go 0 before the next clock edge, and no stale result SHALL emerge after reset is released.
REQ-040 Bench SHALL check that in_valid=0 with varying a/b produces no out_valid.
